// File: rtl/cartesian_to_polar_pkg.sv
// rtl/cartesian_to_polar_pkg.sv - shared sample types and arbiter helpers
//
// complex_t : {imag, re} signed Q15 values, each sign-extended into a 32-bit lane
// polar_t   : {magnitude Q15 [63:32], phase Q31 [31:0]}
// arb_state_t : request-side grant state (open search / held across a core stall)

package cartesian_to_polar_pkg;

   localparam int SAMPLE_WIDTH = 64;

   typedef struct packed {
      logic signed [31:0] imag;
      logic signed [31:0] re;
   } complex_t;

   typedef struct packed {
      logic signed [31:0] magnitude;
      logic signed [31:0] phase;
   } polar_t;

   typedef enum logic {
      ARB_OPEN = 1'b0,
      ARB_HELD = 1'b1
   } arb_state_t;

   // Round-robin successor of idx among n requesters.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cartesian_to_polar_arbiter_tag_fifo.sv
// rtl/cartesian_to_polar_arbiter_tag_fifo.sv - tag FIFO recording the requester of each issued sample
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset (pointers and count only)
//   push, push_data    write a tag; ignored while full
//   pop                drop the head tag; ignored while empty
//   head               first-word-fall-through head tag
//   empty, full        registered-count status
//   count              number of tags held (0..DEPTH)

module tag_fifo
   import cartesian_to_polar_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset: stale entries are never visible past the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/cartesian_to_polar_arbiter.sv
// rtl/cartesian_to_polar_arbiter.sv - round-robin sharing of one cartesian_to_polar core among stream requesters
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   s_valid/s_ready/s_data     per-requester sample inputs (requester i at s_data[i*WIDTH +: WIDTH])
//   m_valid/m_ready            per-requester result handshake
//   m_data                     result bus shared by all requesters, qualified by m_valid[i]
//   c_s_valid/c_s_ready/c_s_data  issue stream to the core
//   c_m_valid/c_m_ready/c_m_data  result stream from the core
//   outstanding                samples issued and not yet returned
//   error                      sticky: core returned a result with no tag outstanding

module cartesian_to_polar_arbiter
   import cartesian_to_polar_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DEPTH     = 16,
   parameter int WIDTH     = SAMPLE_WIDTH,
   localparam int IDX_W    = $clog2(NUM_PORTS),
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_PORTS-1:0]       s_valid,
   output logic [NUM_PORTS-1:0]       s_ready,
   input  logic [NUM_PORTS*WIDTH-1:0] s_data,
   output logic [NUM_PORTS-1:0]       m_valid,
   input  logic [NUM_PORTS-1:0]       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic                       c_s_valid,
   input  logic                       c_s_ready,
   output logic [WIDTH-1:0]           c_s_data,
   input  logic                       c_m_valid,
   output logic                       c_m_ready,
   input  logic [WIDTH-1:0]           c_m_data,
   output logic [CNT_W-1:0]           outstanding,
   output logic                       error
);

   arb_state_t       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] lock_idx;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] head_tag;
   logic             found;
   int unsigned      cand;
   logic             fifo_empty;
   logic             fifo_full;
   logic             issue;
   logic             ret;

   // Unlocked: first valid requester at or above rr_ptr, wrapping.
   // Held: the requester that was presented during a core stall keeps the bus
   // so the core sees a stable sample until it accepts it.
   always_comb begin
      cand  = 0;
      grant = rr_ptr;
      found = 1'b0;
      if (state == ARB_HELD) begin
         grant = lock_idx;
      end else begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!found && s_valid[cand]) begin
               grant = IDX_W'(cand);
               found = 1'b1;
            end
         end
      end
   end

   // Issue side. full uses the registered count, so a same-cycle pop never
   // opens a slot for a push.
   assign c_s_valid = !reset && s_valid[grant] && !fifo_full;
   assign c_s_data  = s_data[grant*WIDTH +: WIDTH];
   assign issue     = c_s_valid && c_s_ready;
   assign s_ready   = issue ? (NUM_PORTS'(1) << grant) : '0;

   // Return side: results come back in issue order, so the FIFO head names
   // the requester owning the result currently on c_m_data.
   assign m_data    = c_m_data;
   assign m_valid   = (!reset && c_m_valid && !fifo_empty) ? (NUM_PORTS'(1) << head_tag) : '0;
   assign c_m_ready = !reset && !fifo_empty && m_ready[head_tag];
   assign ret       = c_m_valid && c_m_ready;

   tag_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (issue),
      .push_data (grant),
      .pop       (ret),
      .head      (head_tag),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (outstanding)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ARB_OPEN;
         rr_ptr   <= '0;
         lock_idx <= '0;
         error    <= 1'b0;
      end else begin
         case (state)
            ARB_OPEN: begin
               if (issue) begin
                  rr_ptr <= IDX_W'(rr_next(int'(grant), NUM_PORTS));
               end else if (c_s_valid) begin
                  state    <= ARB_HELD;
                  lock_idx <= grant;
               end
            end
            ARB_HELD: begin
               if (issue) begin
                  state  <= ARB_OPEN;
                  rr_ptr <= IDX_W'(rr_next(int'(grant), NUM_PORTS));
               end
            end
            default: state <= ARB_OPEN;
         endcase
         if (c_m_valid && fifo_empty) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cartesian_to_polar_arbiter.sv
// tb/tb_cartesian_to_polar_arbiter.sv - self-checking bench for cartesian_to_polar_arbiter

module tb_cartesian_to_polar_arbiter;

   localparam int NP    = 4;
   localparam int DEPTH = 16;
   localparam int W     = 64;
   localparam int LAT   = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NP-1:0]   s_valid, s_ready, m_valid, m_ready;
   logic [NP*W-1:0] s_data;
   logic [W-1:0]    m_data, c_s_data, c_m_data;
   logic            c_s_valid, c_s_ready, c_m_valid, c_m_ready, error;
   logic [CW-1:0]   outstanding;

   logic [NP-1:0]   src_en = '0;
   logic            core_ready = 1'b1, ret_en = 1'b0, force_spur = 1'b0;
   int              src_seq[NP], exp_seq[NP], rx_port[NP], rx_base[NP];
   int              checks = 0, errors = 0, cyc = 0;

   typedef struct { logic [W-1:0] d; int t; } core_ent_t;
   core_ent_t       cq[$];
   int              issue_log[$], issue_cyc[$];
   logic            head_ready = 1'b0;
   logic [W-1:0]    head_data = '0;
   logic            in_fire = 1'b0, out_fire = 1'b0, prev_stall = 1'b0;
   logic [W-1:0]    in_data = '0, prev_data = '0;
   logic [NP-1:0]   hs = '0;

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input int p, input int s);
      return {16'(p), 16'hC0DE, 32'(s)};
   endfunction

   assign s_valid   = src_en;
   assign c_s_ready = core_ready;
   assign c_m_valid = force_spur | (ret_en & head_ready & ~reset);
   assign c_m_data  = force_spur ? 64'hDEAD_BEEF_0000_0000 : ~head_data;

   always_comb begin
      s_data = '0;
      for (int i = 0; i < NP; i++) s_data[i*W +: W] = mk(i, src_seq[i]);
   end

   cartesian_to_polar_arbiter #(.NUM_PORTS(NP), .DEPTH(DEPTH), .WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .c_s_valid(c_s_valid), .c_s_ready(c_s_ready), .c_s_data(c_s_data),
      .c_m_valid(c_m_valid), .c_m_ready(c_m_ready), .c_m_data(c_m_data),
      .outstanding(outstanding), .error(error)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sample handshakes mid-cycle; score routed results against the tag encoded in each sample.
   always @(negedge clk) begin
      logic [W-1:0] x;
      in_fire  = c_s_valid && c_s_ready;
      in_data  = c_s_data;
      out_fire = c_m_valid && c_m_ready;
      hs       = s_valid & s_ready;
      if (in_fire) begin
         issue_log.push_back(int'(c_s_data[63:48]));
         issue_cyc.push_back(cyc);
      end
      if (m_valid != '0) chk("m_valid_onehot", 64'($onehot(m_valid)), 64'd1);
      if (s_ready != '0) chk("s_ready_onehot", 64'($onehot(s_ready)), 64'd1);
      for (int i = 0; i < NP; i++) begin
         if (m_valid[i] && m_ready[i]) begin
            x = ~m_data;
            chk("rx_port", 64'(x[63:48]), 64'(i));
            chk("rx_seq", 64'(x[31:0]), 64'(exp_seq[i]));
            exp_seq[i] = int'(x[31:0]) + 1;
            rx_port[i]++;
         end
      end
      if (prev_stall && !reset) begin
         chk("stall_valid_held", 64'(c_s_valid), 64'd1);
         chk("stall_data_held", c_s_data, prev_data);
      end
      prev_stall = c_s_valid && !c_s_ready && !reset;
      prev_data  = c_s_data;
   end

   // Fixed-latency core model: output = ~input, LAT cycles after acceptance.
   always @(posedge clk) begin
      if (reset) cq.delete();
      else begin
         if (out_fire && cq.size() > 0) void'(cq.pop_front());
         if (in_fire) cq.push_back('{d: in_data, t: cyc + LAT});
      end
      cyc++;
      in_fire  = 1'b0;
      out_fire = 1'b0;
      #1;
      for (int i = 0; i < NP; i++) if (hs[i]) src_seq[i]++;
      hs = '0;
      head_ready = 1'b0;
      head_data  = '0;
      if (cq.size() > 0) begin
         head_ready = (cq[0].t <= cyc);
         head_data  = cq[0].d;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NP; i++) begin
         exp_seq[i] = src_seq[i];
         rx_base[i] = rx_port[i];
      end
      issue_log.delete();
      issue_cyc.delete();
   endtask

   task automatic drain(input string name);
      int n = 0;
      src_en = '0;
      ret_en = 1'b1;
      m_ready = '1;
      while ((outstanding != '0 || cq.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk({name, "_drain_in_time"}, 64'(n < 500), 64'd1);
      chk({name, "_outstanding_zero"}, 64'(outstanding), 64'd0);
      // Every sample issued from port p since the last reset came back on port p.
      for (int p = 0; p < NP; p++) begin
         int cnt = 0;
         foreach (issue_log[k]) if (issue_log[k] == p) cnt++;
         chk({name, "_routed_count"}, 64'(rx_port[p] - rx_base[p]), 64'(cnt));
      end
   endtask

   typedef struct { logic [NP-1:0] valid; logic [NP-1:0] exp_ready; int exp_port; } vec_t;
   vec_t tv[10];

   initial begin
      int n;
      logic [W-1:0] held;
      for (int i = 0; i < NP; i++) begin
         src_seq[i] = 0; exp_seq[i] = 0; rx_port[i] = 0; rx_base[i] = 0;
      end

      // Hand-computed grant sequence from rr=0, core always ready.
      tv[0] = '{4'b1111, 4'b0001, 0};
      tv[1] = '{4'b1111, 4'b0010, 1};
      tv[2] = '{4'b0001, 4'b0001, 0};
      tv[3] = '{4'b1000, 4'b1000, 3};
      tv[4] = '{4'b0110, 4'b0010, 1};
      tv[5] = '{4'b0110, 4'b0100, 2};
      tv[6] = '{4'b0011, 4'b0001, 0};
      tv[7] = '{4'b0000, 4'b0000, 0};
      tv[8] = '{4'b1001, 4'b1000, 3};
      tv[9] = '{4'b0100, 4'b0100, 2};

      // Reset state: handshake outputs forced low even with every input active.
      src_en = '1; m_ready = '1; core_ready = 1'b1;
      #12;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_c_s_valid", 64'(c_s_valid), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      chk("rst_c_m_ready", 64'(c_m_ready), 64'd0);
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      src_en = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      issue_log.delete(); issue_cyc.delete();

      // Grant table.
      for (int v = 0; v < 10; v++) begin
         src_en = tv[v].valid;
         @(negedge clk);
         chk("tbl_s_ready", 64'(s_ready), 64'(tv[v].exp_ready));
         chk("tbl_c_s_valid", 64'(c_s_valid), 64'(tv[v].exp_ready != '0));
         if (tv[v].exp_ready != '0) chk("tbl_c_s_data_port", 64'(c_s_data[63:48]), 64'(tv[v].exp_port));
         @(posedge clk); #1;
      end
      src_en = '0;
      chk("tbl_outstanding", 64'(outstanding), 64'd9);
      drain("tbl");

      // Round-robin, all ports requesting.
      do_reset();
      src_en = '1;
      n = 0;
      while (issue_log.size() < 64 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rr_issue_in_time", 64'(n < 200), 64'd1);
      if (issue_log.size() >= 64) begin
         for (int k = 0; k < 64; k++) chk("rr_order", 64'(issue_log[k]), 64'(k % 4));
         chk("rr_one_per_clk", 64'(issue_cyc[63] - issue_cyc[0]), 64'd63);
      end
      drain("rr");

      // Single active port takes every cycle.
      do_reset();
      src_en = 4'b0100;
      n = 0;
      while (issue_log.size() < 32 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("single_in_time", 64'(n < 200), 64'd1);
      if (issue_log.size() >= 32) begin
         chk("single_one_per_clk", 64'(issue_cyc[31] - issue_cyc[0]), 64'd31);
         for (int k = 0; k < 32; k++) chk("single_port", 64'(issue_log[k]), 64'd2);
      end
      drain("single");

      // Input backpressure: stall granted to port 1, ports 0 and 3 raise meanwhile.
      do_reset();
      ret_en = 1'b1; m_ready = '1;
      src_en = 4'b0010; core_ready = 1'b0;
      @(negedge clk);
      chk("bp_stall_valid", 64'(c_s_valid), 64'd1);
      chk("bp_stall_port", 64'(c_s_data[63:48]), 64'd1);
      held = c_s_data;
      @(posedge clk); #1;
      src_en = 4'b1011;
      @(negedge clk);
      chk("bp_lock_data", c_s_data, held);
      chk("bp_lock_no_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      core_ready = 1'b1;
      @(negedge clk);
      chk("bp_port1_issues", 64'(s_ready), 64'b0010);
      chk("bp_port1_data", c_s_data, held);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_port3_next", 64'(s_ready), 64'b1000);
      src_en = '1;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         core_ready = (k % 3 == 0);
      end
      core_ready = 1'b1;
      cycles(1);
      drain("bp");

      // Output backpressure until full, then release.
      do_reset();
      ret_en = 1'b1; m_ready = 4'b1110; src_en = 4'b0001;
      n = 0;
      while (outstanding != CW'(DEPTH) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("full_reached", 64'(outstanding), 64'(DEPTH));
      cycles(3);
      @(negedge clk);
      chk("full_hold", 64'(outstanding), 64'(DEPTH));
      chk("full_c_s_valid", 64'(c_s_valid), 64'd0);
      chk("full_m_valid", 64'(m_valid), 64'b0001);
      chk("full_c_m_ready", 64'(c_m_ready), 64'd0);
      @(posedge clk); #1;
      drain("full");
      chk("full_all_returned", 64'(rx_port[0] - rx_base[0]), 64'(DEPTH));

      // Spurious result with nothing outstanding.
      chk("spur_error_before", 64'(error), 64'd0);
      force_spur = 1'b1;
      @(negedge clk);
      chk("spur_c_m_ready", 64'(c_m_ready), 64'd0);
      chk("spur_m_valid", 64'(m_valid), 64'd0);
      @(posedge clk); #1;
      force_spur = 1'b0;
      chk("spur_error_set", 64'(error), 64'd1);
      cycles(10);
      chk("spur_error_sticky", 64'(error), 64'd1);

      // Asynchronous reset with 5 outstanding.
      do_reset();
      ret_en = 1'b0; m_ready = '1; src_en = '1;
      repeat (5) @(posedge clk);
      #1;
      src_en = '0;
      chk("mid_outstanding5", 64'(outstanding), 64'd5);
      src_en = '1; ret_en = 1'b1;
      #1;
      chk("mid_pre_c_s_valid", 64'(c_s_valid), 64'd1);
      chk("mid_pre_m_valid", 64'(m_valid), 64'b0001);
      reset = 1'b1;
      #1;
      chk("mid_outstanding", 64'(outstanding), 64'd0);
      chk("mid_s_ready", 64'(s_ready), 64'd0);
      chk("mid_c_s_valid", 64'(c_s_valid), 64'd0);
      chk("mid_m_valid", 64'(m_valid), 64'd0);
      chk("mid_c_m_ready", 64'(c_m_ready), 64'd0);
      chk("mid_error_cleared", 64'(error), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NP; i++) begin
         exp_seq[i] = src_seq[i];
         rx_base[i] = rx_port[i];
      end
      issue_log.delete(); issue_cyc.delete();
      @(negedge clk);
      chk("mid_first_port0", 64'(s_ready), 64'b0001);
      cycles(10);
      drain("mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule

// File: doc/cartesian_to_polar_arbiter.md
Name: cartesian_to_polar_arbiter

Overview:
- Shares one cartesian_to_polar instance between NUM_PORTS stream requesters.
- Round-robin arbitration on the request side; each issued sample's source index is pushed into a tag FIFO.
- Results come back in issue order; the FIFO head routes each result to its requester.
- Sits between the per-channel front ends and a single external cartesian_to_polar core.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
DEPTH, 16, max outstanding samples in the core; power of 2, at least the core pipeline depth for full throughput
WIDTH, 64, sample width: in {Q,I} Q15 pairs, out {magnitude,phase}

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
s_valid  in  NUM_PORTS  per-requester input valid
s_ready  out  NUM_PORTS  per-requester input ready
s_data  in  NUM_PORTS*WIDTH  requester i at bits [i*WIDTH +: WIDTH]
m_valid  out  NUM_PORTS  per-requester result valid
m_ready  in  NUM_PORTS  per-requester result ready
m_data  out  WIDTH  result, shared by all requesters; qualified by m_valid[i]
c_s_valid  out  1  to core s_valid
c_s_ready  in  1  from core s_ready
c_s_data  out  WIDTH  to core s_data
c_m_valid  in  1  from core m_valid
c_m_ready  out  1  to core m_ready
c_m_data  in  WIDTH  from core m_data
outstanding  out  $clog2(DEPTH)+1  samples issued but not yet returned
error  out  1  sticky: core produced a result with no tag outstanding

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset state:
  - rr pointer 0, tag FIFO empty, outstanding 0, lock 0, error 0.
  - While reset is high, s_ready, c_s_valid, m_valid and c_m_ready are forced 0.
  - Reset mid-operation discards all tags. The core must share the same reset.
- Grant selection (combinational):
  - When unlocked, grant is the first i with s_valid[i]=1, searching from the rr pointer upward modulo NUM_PORTS.
  - When locked, grant is the registered locked index.
- Issue side:
  - c_s_valid = any s_valid[grant] && !full, where full means outstanding==DEPTH using the registered count.
  - c_s_data = s_data[grant].
  - s_ready[grant] = c_s_valid && c_s_ready. All other s_ready bits are 0.
  - Issue event = c_s_valid && c_s_ready. On issue: push grant into the FIFO, rr pointer <= grant+1 mod NUM_PORTS, lock <= 0.
- Stall lock (keeps the core input stable per handshake rules):
  - If c_s_valid && !c_s_ready: lock <= 1 and the grant index is stored.
  - Grant stays fixed until issue, even if a higher-priority requester raises valid.
- Return side:
  - head = FIFO head tag.
  - m_valid[head] = c_m_valid && !empty; other m_valid bits are 0.
  - m_data = c_m_data.
  - c_m_ready = !empty && m_ready[head].
  - Return event = c_m_valid && c_m_ready: pop the FIFO.
- Result arriving with an empty FIFO:
  - c_m_ready stays 0 and error <= 1.
  - error stays set until reset.
- Counting:
  - Push only: outstanding +1. Pop only: -1. Push and pop in the same cycle: unchanged.
  - At full, push is blocked even if a pop occurs in the same cycle.
- Throughput and latency:
  - One issue per cycle when the core is ready; no added latency on either path (all combinational routing).
  - Peak rate of 1 sample/clk is sustained when DEPTH ≥ core latency.
- Fairness:
  - A continuously requesting port waits at most NUM_PORTS-1 issues.
  - A single active port gets every cycle.
- Ordering: results return strictly in issue order.

Decomposition:
- cartesian_to_polar_pkg holds:
  - complex_t, a 64-bit {imag,real} pair of signed Q15 values.
  - polar_t, {magnitude Q15 [63:32], phase Q31 [31:0]}.
  - SAMPLE_WIDTH=64.
- Sub-module tag_fifo: synchronous FIFO, width $clog2(NUM_PORTS), depth DEPTH, with count output and first-word-fall-through head.

Test Plan:
- Single port:
  - Stimulus: NUM_PORTS=4, only port 2 streams 32 samples polar(1/(1+n), π/n), all m_ready=1.
  - Required: 32 results on port 2 only, magnitude within 1 LSB, one issue/clk after pipeline fill.
- Round-robin:
  - Stimulus: all 4 ports hold s_valid=1.
  - Required: issue order 0,1,2,3,0,1,… for 64 samples; results routed back with matching tags, none misrouted.
- Input backpressure:
  - Stimulus: c_s_ready toggles 1-in-3 while port 3 raises valid during a stall granted to port 1.
  - Required: c_s_data is unchanged until port 1 issues; port 3 goes next.
- Output backpressure / full:
  - Stimulus: m_ready[0]=0 with port 0 streaming, DEPTH=16.
  - Required: outstanding reaches 16, c_s_valid drops, no loss.
  - Stimulus: release m_ready.
  - Required: all 16 results drain in order.
- Spurious result:
  - Stimulus: force c_m_valid=1 with the FIFO empty.
  - Required: error=1, c_m_ready=0, no m_valid asserted; error is still 1 after 10 clocks.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously with 5 outstanding.
  - Required: outstanding=0, all handshake outputs immediately 0.
  - After release: first issue goes to port 0.
